alu_arbiter: RTL and testbench

Shares the single combinational ALU of the MIPS datapath between two requesters, for example the EX stage and a multi-cycle helper unit. Each requester presents an instruction word and two operands through a valid/ready handshake. The arbiter picks a winner round-robin, registers the operands onto the ALU inputs, and captures the ALU result and flags one cycle later. It returns them on a single tagged response channel with backpressure.

---
 rtl/alu_arbiter.sv | 177 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared MIPS ALU: arbitration, operand register, tagged response.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins) instead of round-robin.
module alu_arbiter #(
    parameter int DW = 32,
    parameter int FW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [31:0]   req0_instr,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [31:0]   req1_instr,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic [31:0]   alu_instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic [FW-1:0] alu_flags,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_result,
    output logic [FW-1:0] rsp_flags,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   alu_instr_q, alu_instr_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic          grant_id_q, grant_id_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [DW-1:0] rsp_result_q, rsp_result_d;
    logic [FW-1:0] rsp_flags_q, rsp_flags_d;
    logic          busy_q, busy_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic          last_grant_q, last_grant_d;
`endif

    logic can_accept_s;
    logic win_id_s;
    logic accept_s;

    // Winner selection and accept qualification; rst_n gates the readies during reset.
    always_comb begin
        case (state_q)
            S_IDLE:  can_accept_s = 1'b1;
            S_RESP:  can_accept_s = rsp_ready;
            default: can_accept_s = 1'b0;
        endcase
`ifdef ALU_ARB_FIXED_PRIO_EN
        win_id_s = ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            win_id_s = ~last_grant_q;
        end else begin
            win_id_s = req1_valid;
        end
`endif
        accept_s = can_accept_s & (req0_valid | req1_valid) & rst_n;
    end

    assign req0_ready = accept_s & ~win_id_s;
    assign req1_ready = accept_s & win_id_s;

    // Next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        alu_instr_d  = alu_instr_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        grant_id_d   = grant_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = grant_id_q;
                rsp_result_d = alu_result;
                rsp_flags_d  = alu_flags;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept_s ? S_EXEC : S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        // Operands are only overwritten by a new accept; they are never cleared while idle.
        if (accept_s) begin
            alu_instr_d  = win_id_s ? req1_instr : req0_instr;
            alu_a_d      = win_id_s ? req1_a : req0_a;
            alu_b_d      = win_id_s ? req1_b : req0_b;
            grant_id_d   = win_id_s;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_d = win_id_s;
`endif
        end else begin
            grant_id_d = grant_id_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            alu_instr_q  <= 32'h0;
            alu_a_q      <= {DW{1'b0}};
            alu_b_q      <= {DW{1'b0}};
            grant_id_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= {DW{1'b0}};
            rsp_flags_q  <= {FW{1'b0}};
            busy_q       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            alu_instr_q  <= alu_instr_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            grant_id_q   <= grant_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            busy_q       <= busy_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign alu_instr  = alu_instr_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU closing the loop on alu_* -> alu_result/flags.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int FW = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    localparam logic [31:0] I_ADD   = 32'h00051020;
    localparam logic [31:0] I_SUB   = 32'h00051022;
    localparam logic [31:0] I_ADDIU = 32'h2508000C;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_ready;
    logic [31:0]   req0_instr;
    logic [DW-1:0] req0_a, req0_b;
    logic          req1_valid, req1_ready;
    logic [31:0]   req1_instr;
    logic [DW-1:0] req1_a, req1_b;
    logic [31:0]   alu_instr;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [FW-1:0] alu_flags;
    logic          rsp_valid, rsp_ready, rsp_id, busy;
    logic [DW-1:0] rsp_result;
    logic [FW-1:0] rsp_flags;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.DW(DW), .FW(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Reference ALU: flags are {negative, zero, lsb}.
    function automatic logic [34:0] alu_model(input logic [31:0] ins, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20, 6'h21: r = a + b;
                    6'h22, 6'h23: r = a - b;
                    6'h24:        r = a & b;
                    6'h25:        r = a | b;
                    default:      r = 32'h0;
                endcase
            end
            6'h09:   r = a + {{16{ins[15]}}, ins[15:0]};
            default: r = 32'h0;
        endcase
        return {r[31], (r == 32'h0), r[0], r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_instr, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic e;
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req0_instr = I_ADD;
        req0_a     = 32'h0000000A;
        req0_b     = 32'h00000005;
        req1_valid = 1'b0;
        req1_instr = I_ADDIU;
        req1_a     = 32'h00000010;
        req1_b     = 32'h00000099;
        rsp_ready  = 1'b1;
        step();
        step();
        // Reset values, with a valid request present.
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_result", rsp_result, 32'h0);
        check("rst_rsp_flags", rsp_flags, 3'b000);
        check("rst_alu_instr", alu_instr, 32'h0);
        check("rst_alu_a", alu_a, 32'h0);

        // Single add.
        rst_n = 1'b1;
        #1;
        check("add_ready0", req0_ready, 1'b1);
        check("add_ready1", req1_ready, 1'b0);
        step();
        req0_valid = 1'b0;
        check("add_exec_busy", busy, 1'b1);
        check("add_alu_instr", alu_instr, I_ADD);
        check("add_alu_a", alu_a, 32'h0000000A);
        check("add_exec_rsp_valid", rsp_valid, 1'b0);
        check("add_exec_ready0", req0_ready, 1'b0);
        step();
        check("add_rsp_valid", rsp_valid, 1'b1);
        check("add_rsp_id", rsp_id, 1'b0);
        check("add_rsp_result", rsp_result, 32'h0000000F);
        check("add_rsp_flags", rsp_flags, 3'b001);
        step();
        check("add_idle_busy", busy, 1'b0);
        check("add_idle_rsp_valid", rsp_valid, 1'b0);
        check("add_alu_hold", alu_a, 32'h0000000A);

        // Contention after reset: round-robin 0,1,0,1 back-to-back.
        rst_n = 1'b0;
        step();
        rst_n      = 1'b1;
        req0_instr = I_SUB;
        req0_a     = 32'h0000000A;
        req0_b     = 32'h00000005;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = FIXED ? 1'b0 : k[0];
            #1;
            check("cont_ready0", req0_ready, !e);
            check("cont_ready1", req1_ready, e);
            step();
            check("cont_busy", busy, 1'b1);
            check("cont_alu_instr", alu_instr, e ? I_ADDIU : I_SUB);
            step();
            check("cont_rsp_valid", rsp_valid, 1'b1);
            check("cont_rsp_id", rsp_id, e);
            check("cont_rsp_result", rsp_result, e ? 32'h0000001C : 32'h00000005);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        check("cont_idle_busy", busy, 1'b0);
        check("cont_idle_rsp_valid", rsp_valid, 1'b0);

        // Backpressure with req1 waiting.
        req0_instr = I_ADD;
        req0_a     = 32'h00000003;
        req0_b     = 32'h00000004;
        req0_valid = 1'b1;
        #1;
        check("bp_ready0", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        rsp_ready  = 1'b0;
        #1;
        check("bp_exec_ready1", req1_ready, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_result", rsp_result, 32'h00000007);
            check("bp_rsp_flags", rsp_flags, 3'b001);
            check("bp_rsp_id", rsp_id, 1'b0);
            check("bp_ready1", req1_ready, 1'b0);
            check("bp_alu_a", alu_a, 32'h00000003);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready1", req1_ready, 1'b1);
        check("bp_release_ready0", req0_ready, 1'b0);
        step();
        req1_valid = 1'b0;
        check("bp_b2b_rsp_valid", rsp_valid, 1'b0);
        check("bp_b2b_alu_a", alu_a, 32'h00000010);
        check("bp_b2b_busy", busy, 1'b1);
        step();
        check("bp_r1_rsp_valid", rsp_valid, 1'b1);
        check("bp_r1_rsp_id", rsp_id, 1'b1);
        check("bp_r1_rsp_result", rsp_result, 32'h0000001C);
        check("bp_r1_rsp_flags", rsp_flags, 3'b000);
        step();
        check("bp_idle_busy", busy, 1'b0);

        // Reset while in EXEC: op is dropped.
        req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        check("rmid_exec_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rmid_busy", busy, 1'b0);
        check("rmid_rsp_valid", rsp_valid, 1'b0);
        check("rmid_alu_a", alu_a, 32'h0);
        check("rmid_alu_instr", alu_instr, 32'h0);
        check("rmid_rsp_result", rsp_result, 32'h0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rmid_post_rsp_valid", rsp_valid, 1'b0);
            check("rmid_post_busy", busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
